airlock_seq_ctrl: RTL and testbench
===================================

Name: airlock_seq_ctrl

Overview:
Parametrised next-generation airlock controller for the bathysphere habitat. It sequences arrival and departure cycles: wait, pressurise or depressurise, then open and close the outer and inner doors. Unlike the previous interlock, the wait, fill and drain timers are internal, pressure state is tracked internally, and an unauthorised door-open fault is detected and latched. It sits between the top-level switch/key decode and the LEDR drivers.

Parameters:
WAIT_CYCLES, 8, clock cycles spent in WAIT before pressure action (>=1)
FILL_CYCLES, 6, clock cycles spent in FILL (>=1)
DRAIN_CYCLES, 6, clock cycles spent in DRAIN (>=1)
CNT_W, 8, timer counter width; must hold max of the three cycle counts
DRAIN_AFTER_DEPART, 1, 1 = drain to low after departure ends; 0 = stay high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
arrive_req  in  1  bathysphere arriving (level; sampled only in idle states)
depart_req  in  1  bathysphere departing (level; sampled only in idle states)
person_in  in  1  occupant present in chamber
inner_sw  in  1  inner door physical switch, 1 = open
outer_sw  in  1  outer door physical switch, 1 = open
clear_fault  in  1  fault acknowledge
inner_door  out  1  inner door permitted/unlocked
outer_door  out  1  outer door permitted/unlocked
filling  out  1  high while in FILL
draining  out  1  high while in DRAIN
waiting  out  1  high while in WAIT
pressure_high  out  1  chamber pressure state
done  out  1  one-cycle pulse on sequence completion
fault  out  1  latched fault
state_leds  out  4  state code for LEDR[7:4]

Behaviour:
- Reset (async, reset=0): state IDLE_LOW; all outputs 0; state_leds=4'h4; timer cleared.
- State codes: IDLE_LOW 4, IDLE_HIGH 5, WAIT 3, FILL C, DRAIN D, OUTER_OPEN 8, INNER_OPEN A, FAULT F. state_leds is a registered copy of the state.
- All outputs are registered and are Moore functions of the state plus the internal direction flag: waiting=WAIT, filling=FILL, draining=DRAIN, outer_door=OUTER_OPEN, inner_door=INNER_OPEN.
- Idle states: arrive_req has priority over depart_req if both are high. An accepted request latches a direction flag (ARR or DEP) and enters WAIT. Requests are ignored in all other states.
- WAIT, FILL and DRAIN each last exactly their *_CYCLES cycles. The counter loads on entry and the state exits on the cycle it reaches terminal count.
- After WAIT: ARR needs high pressure and DEP needs low. If the chamber already matches, go straight to the first door (ARR: OUTER_OPEN, DEP: INNER_OPEN). Otherwise go to FILL or DRAIN first.
- FILL exit sets pressure_high=1. DRAIN exit clears it.
- Door states have two phases: wait for sw=1 (opened), then wait for sw=0 (closed). The transition fires on the closing edge.
- ARR: OUTER_OPEN close -> DRAIN -> INNER_OPEN. Inner close with person_in=0 -> IDLE_LOW and done pulses. Inner close with person_in=1 stays in INNER_OPEN and restarts phase 1.
- DEP: INNER_OPEN close with person_in=1 -> FILL -> OUTER_OPEN. Inner close with person_in=0 aborts to IDLE_LOW with no done pulse. Outer close with person_in=0 -> DRAIN -> IDLE_LOW if DRAIN_AFTER_DEPART=1, else IDLE_HIGH; done pulses on entry to the idle state.
- Fault: any switch reads 1 while its door output is 0, or either switch is 1 during FILL or DRAIN -> FAULT next cycle.
  - In FAULT: fault=1; door, filling and draining outputs all 0; timer frozen.
  - Exit: clear_fault=1 with both switches 0 -> DRAIN (full DRAIN_CYCLES) -> IDLE_LOW, fault cleared on DRAIN entry, no done pulse.
  - Fault detection has priority over every other transition.
- Reset asserted mid-sequence aborts immediately to the reset state. pressure_high restarts at 0.

Test Plan:
- Defaults with WAIT=4, FILL=3, DRAIN=3. From IDLE_LOW, arrive_req pulse -> waiting high for 4 cycles, then filling high for 3 cycles, pressure_high=1, outer_door=1. Drive outer_sw 1->0 with person_in=1 -> draining for 3 cycles, then inner_door=1. Drive inner_sw 1->0 with person_in=0 -> IDLE_LOW (4'h4) with done=1 for exactly 1 cycle.
- Departure from IDLE_LOW: depart_req -> WAIT 4 -> INNER_OPEN with no FILL. Inner cycle with person_in=1 -> FILL 3 -> outer cycle with person_in=0 -> DRAIN 3 -> IDLE_LOW and done. Repeat with DRAIN_AFTER_DEPART=0 -> ends in IDLE_HIGH (4'h5), pressure_high=1.
- From IDLE_HIGH: arrive_req -> WAIT then OUTER_OPEN directly, with filling never asserted.
- Drive outer_sw=1 during FILL -> next cycle state_leds=F, fault=1, filling=0. clear_fault while outer_sw=1 -> stays in FAULT. After switches return to 0, clear_fault -> DRAIN 3 cycles -> IDLE_LOW with done=0.
- arrive_req and depart_req high in the same idle cycle -> ARR path taken. Requests raised in the middle of FILL are ignored.
- Assert reset during DRAIN cycle 2 -> all outputs 0 immediately and state_leds=4. After release, arrive_req restarts a full sequence with FILL from pressure low.

Source files
------------

// File: rtl/airlock_seq_ctrl_if.sv
// airlock_seq_ctrl_if: airlock request/switch inputs and door/status outputs; master drives requests and switches, slave is the controller
interface airlock_seq_ctrl_if;
  logic arrive_req;
  logic depart_req;
  logic person_in;
  logic inner_sw;
  logic outer_sw;
  logic clear_fault;
  logic inner_door;
  logic outer_door;
  logic filling;
  logic draining;
  logic waiting;
  logic pressure_high;
  logic done;
  logic fault;
  logic [3:0] state_leds;
  modport master (
    output arrive_req, depart_req, person_in, inner_sw, outer_sw, clear_fault,
    input inner_door, outer_door, filling, draining, waiting, pressure_high, done, fault, state_leds
  );
  modport slave (
    input arrive_req, depart_req, person_in, inner_sw, outer_sw, clear_fault,
    output inner_door, outer_door, filling, draining, waiting, pressure_high, done, fault, state_leds
  );
endinterface

// File: rtl/airlock_seq_ctrl.sv
// airlock_seq_ctrl: airlock arrival/departure sequencer with internal timers, pressure tracking and latched door fault; ports clk, reset (async active-low), bus (slave: requests/switches/clear_fault in, doors/status/state_leds out)
module airlock_seq_ctrl #(
  parameter int WAIT_CYCLES = 8,
  parameter int FILL_CYCLES = 6,
  parameter int DRAIN_CYCLES = 6,
  parameter int CNT_W = 8,
  parameter bit DRAIN_AFTER_DEPART = 1
) (
  input logic clk,
  input logic reset,
  airlock_seq_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE_LOW = 4'h4, IDLE_HIGH = 4'h5, WAIT = 4'h3, FILL = 4'hC,
    DRAIN = 4'hD, OUTER_OPEN = 4'h8, INNER_OPEN = 4'hA, FAULT = 4'hF
  } state_t;
  // M_DEP2 marks the second leg of a departure (after the inner door), M_REC a fault recovery drain
  typedef enum logic [1:0] {M_ARR, M_DEP, M_DEP2, M_REC} mode_t;
  state_t state, nxt;
  mode_t mode, mode_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic opened, opened_nxt, press_nxt, done_nxt;
  logic door, sw, closing, tc, timed, fault_det;
  assign door = state == OUTER_OPEN || state == INNER_OPEN;
  assign sw = state == INNER_OPEN ? bus.inner_sw : bus.outer_sw;
  assign closing = door && opened && !sw;
  assign tc = cnt == '0;
  assign timed = state == WAIT || state == FILL || state == DRAIN;
  // door outputs are zero in FILL, DRAIN and FAULT, so this also covers any open switch there
  assign fault_det = (bus.inner_sw && !bus.inner_door) || (bus.outer_sw && !bus.outer_door);
  always_comb begin
    nxt = state;
    mode_nxt = mode;
    press_nxt = bus.pressure_high;
    done_nxt = 1'b0;
    if (fault_det) begin
      nxt = FAULT;
      mode_nxt = M_REC;
    end else begin
      case (state)
        IDLE_LOW, IDLE_HIGH: begin
          if (bus.arrive_req || bus.depart_req) begin
            nxt = WAIT;
            mode_nxt = bus.arrive_req ? M_ARR : M_DEP;
          end
        end
        WAIT: if (tc) nxt = mode == M_ARR ? (bus.pressure_high ? OUTER_OPEN : FILL)
                                          : (bus.pressure_high ? DRAIN : INNER_OPEN);
        FILL: begin
          if (tc) begin
            nxt = OUTER_OPEN;
            press_nxt = 1'b1;
          end
        end
        DRAIN: begin
          if (tc) begin
            press_nxt = 1'b0;
            nxt = mode == M_ARR || mode == M_DEP ? INNER_OPEN : IDLE_LOW;
            done_nxt = mode == M_DEP2;
          end
        end
        OUTER_OPEN: begin
          if (closing && mode == M_ARR) nxt = DRAIN;
          else if (closing && !bus.person_in) begin
            nxt = DRAIN_AFTER_DEPART ? DRAIN : IDLE_HIGH;
            done_nxt = !DRAIN_AFTER_DEPART;
          end
        end
        INNER_OPEN: begin
          if (closing && bus.person_in && mode == M_DEP) begin
            nxt = FILL;
            mode_nxt = M_DEP2;
          end else if (closing && !bus.person_in) begin
            nxt = IDLE_LOW;
            done_nxt = mode == M_ARR;
          end
        end
        FAULT: if (bus.clear_fault && !bus.inner_sw && !bus.outer_sw) nxt = DRAIN;
        default: nxt = IDLE_LOW;
      endcase
    end
  end
  // a door close that keeps the state (occupant still inside) drops opened, restarting phase 1
  assign opened_nxt = door && nxt == state && !closing && (opened || sw);
  // entering a non-timed state (including FAULT) keeps the count, which freezes the timer
  assign cnt_nxt = nxt != state ? (nxt == WAIT ? CNT_W'(WAIT_CYCLES - 1) :
                                   nxt == FILL ? CNT_W'(FILL_CYCLES - 1) :
                                   nxt == DRAIN ? CNT_W'(DRAIN_CYCLES - 1) : cnt)
                                : (timed && !tc ? cnt - CNT_W'(1) : cnt);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE_LOW;
      mode <= M_ARR;
      cnt <= '0;
      opened <= 1'b0;
      bus.inner_door <= 1'b0;
      bus.outer_door <= 1'b0;
      bus.filling <= 1'b0;
      bus.draining <= 1'b0;
      bus.waiting <= 1'b0;
      bus.pressure_high <= 1'b0;
      bus.done <= 1'b0;
      bus.fault <= 1'b0;
      bus.state_leds <= 4'h4;
    end else begin
      state <= nxt;
      mode <= mode_nxt;
      cnt <= cnt_nxt;
      opened <= opened_nxt;
      bus.inner_door <= nxt == INNER_OPEN;
      bus.outer_door <= nxt == OUTER_OPEN;
      bus.filling <= nxt == FILL;
      bus.draining <= nxt == DRAIN;
      bus.waiting <= nxt == WAIT;
      bus.pressure_high <= press_nxt;
      bus.done <= done_nxt;
      bus.fault <= nxt == FAULT;
      bus.state_leds <= nxt;
    end
  end
endmodule

// File: tb/tb_airlock_seq_ctrl.sv
// tb_airlock_seq_ctrl: scoreboard bench for airlock_seq_ctrl, one instance draining after departure and one staying high
module tb_airlock_seq_ctrl;
  localparam int ARR = 5, DEP = 4, PI = 3, ISW = 2, OSW = 1, CLR = 0;
  typedef struct packed {
    logic dut;
    logic [3:0] leds;
    logic [7:0] outs;
    logic [7:0] dwell;
  } exp_t;
  logic clk = 1'b0;
  logic [1:0] rst_n;
  logic [5:0] drv [2];
  logic [11:0] obs [2];
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  always #5 clk = ~clk;
  airlock_seq_ctrl_if bus0 ();
  airlock_seq_ctrl_if bus1 ();
  airlock_seq_ctrl #(.WAIT_CYCLES(4), .FILL_CYCLES(3), .DRAIN_CYCLES(3), .CNT_W(8), .DRAIN_AFTER_DEPART(1)) dut0 (
    .clk(clk), .reset(rst_n[0]), .bus(bus0));
  airlock_seq_ctrl #(.WAIT_CYCLES(4), .FILL_CYCLES(3), .DRAIN_CYCLES(3), .CNT_W(8), .DRAIN_AFTER_DEPART(0)) dut1 (
    .clk(clk), .reset(rst_n[1]), .bus(bus1));
  assign {bus0.arrive_req, bus0.depart_req, bus0.person_in, bus0.inner_sw, bus0.outer_sw, bus0.clear_fault} = drv[0];
  assign {bus1.arrive_req, bus1.depart_req, bus1.person_in, bus1.inner_sw, bus1.outer_sw, bus1.clear_fault} = drv[1];
  assign obs[0] = {bus0.state_leds, bus0.inner_door, bus0.outer_door, bus0.filling, bus0.draining,
                   bus0.waiting, bus0.pressure_high, bus0.done, bus0.fault};
  assign obs[1] = {bus1.state_leds, bus1.inner_door, bus1.outer_door, bus1.filling, bus1.draining,
                   bus1.waiting, bus1.pressure_high, bus1.done, bus1.fault};
  function automatic logic [7:0] outs_of(input logic [3:0] s, input logic p, input logic d);
    return {s == 4'hA, s == 4'h8, s == 4'hC, s == 4'hD, s == 4'h3, p, d, s == 4'hF};
  endfunction
  task automatic push(input int g, input logic [3:0] s, input logic p, input logic d, input int dw);
    exp_t e;
    e.dut = g[0];
    e.leds = s;
    e.outs = outs_of(s, p, d);
    e.dwell = dw[7:0];
    q.push_back(e);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_leds(input int g, input logic [3:0] s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (obs[g][11:8] != s && n < 100);
    if (obs[g][11:8] != s) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: state %h, required %h", g, obs[g][11:8], s);
    end
  endtask
  task automatic pulse(input int g, input int b);
    drv[g][b] = 1'b1;
    step(1);
    drv[g][b] = 1'b0;
  endtask
  task automatic door(input int g, input int b, input logic pi);
    drv[g][PI] = pi;
    drv[g][b] = 1'b1;
    step(2);
    drv[g][b] = 1'b0;
    step(1);
  endtask
  initial begin
    logic [3:0] prev [2];
    int cyc [2];
    int dw [2];
    exp_t e;
    prev = '{4'h4, 4'h4};
    cyc = '{0, 0};
    dw = '{0, 0};
    wait (mon_on);
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (obs[g][11:8] != prev[g]) begin
          if (dw[g] != 0) begin
            checks++;
            if (cyc[g] != dw[g]) begin
              errors++;
              $display("FAIL dwell dut%0d state %h: %0d cycles, required %0d", g, prev[g], cyc[g], dw[g]);
            end
          end
          checks++;
          if (q.size() == 0) begin
            errors++;
            dw[g] = 0;
            $display("FAIL unexpected dut%0d: state %h outs %b, required no change", g, obs[g][11:8], obs[g][7:0]);
          end else begin
            e = q.pop_front();
            dw[g] = int'(e.dwell);
            if (int'(e.dut) != g || e.leds != obs[g][11:8] || e.outs != obs[g][7:0]) begin
              errors++;
              $display("FAIL entry dut%0d: state %h outs %b, required dut%0d state %h outs %b",
                       g, obs[g][11:8], obs[g][7:0], e.dut, e.leds, e.outs);
            end
          end
          cyc[g] = 1;
          prev[g] = obs[g][11:8];
        end else begin
          cyc[g]++;
          if (obs[g][1]) begin
            checks++;
            errors++;
            $display("FAIL done_width dut%0d: done 1 in steady state %h, required 0", g, obs[g][11:8]);
          end
        end
      end
    end
  end
  initial begin
    int n;
    drv[0] = '0;
    drv[1] = '0;
    rst_n = 2'b11;
    #1 rst_n = 2'b00;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (obs[g] != {4'h4, 8'h00}) begin
        errors++;
        $display("FAIL reset dut%0d: %h, required 400", g, obs[g]);
      end
    end
    step(2);
    rst_n = 2'b11;
    mon_on = 1'b1;
    push(0, 4'h3, 0, 0, 4); push(0, 4'hC, 0, 0, 3); push(0, 4'h8, 1, 0, 0);
    pulse(0, ARR);
    wait_leds(0, 4'h8);
    push(0, 4'hD, 1, 0, 3); push(0, 4'hA, 0, 0, 0);
    door(0, OSW, 1);
    wait_leds(0, 4'hA);
    push(0, 4'h4, 0, 1, 0);
    door(0, ISW, 0);
    step(3);
    push(0, 4'h3, 0, 0, 4); push(0, 4'hA, 0, 0, 0);
    pulse(0, DEP);
    wait_leds(0, 4'hA);
    push(0, 4'hC, 0, 0, 3); push(0, 4'h8, 1, 0, 0);
    door(0, ISW, 1);
    wait_leds(0, 4'h8);
    push(0, 4'hD, 1, 0, 3); push(0, 4'h4, 0, 1, 0);
    door(0, OSW, 0);
    wait_leds(0, 4'h4);
    step(2);
    push(1, 4'h3, 0, 0, 4); push(1, 4'hA, 0, 0, 0);
    pulse(1, DEP);
    wait_leds(1, 4'hA);
    push(1, 4'hC, 0, 0, 3); push(1, 4'h8, 1, 0, 0);
    door(1, ISW, 1);
    wait_leds(1, 4'h8);
    push(1, 4'h5, 1, 1, 0);
    door(1, OSW, 0);
    step(3);
    push(1, 4'h3, 1, 0, 4); push(1, 4'h8, 1, 0, 0);
    pulse(1, ARR);
    wait_leds(1, 4'h8);
    push(1, 4'hD, 1, 0, 3); push(1, 4'hA, 0, 0, 0);
    door(1, OSW, 1);
    wait_leds(1, 4'hA);
    push(1, 4'h4, 0, 1, 0);
    door(1, ISW, 0);
    step(3);
    push(0, 4'h3, 0, 0, 4); push(0, 4'hC, 0, 0, 0);
    drv[0][ARR] = 1'b1;
    drv[0][DEP] = 1'b1;
    step(1);
    drv[0][ARR] = 1'b0;
    drv[0][DEP] = 1'b0;
    wait_leds(0, 4'hC);
    push(0, 4'hF, 0, 0, 0);
    drv[0][OSW] = 1'b1;
    step(2);
    drv[0][CLR] = 1'b1;
    step(3);
    drv[0][CLR] = 1'b0;
    drv[0][OSW] = 1'b0;
    step(2);
    push(0, 4'hD, 0, 0, 3); push(0, 4'h4, 0, 0, 0);
    pulse(0, CLR);
    wait_leds(0, 4'h4);
    step(2);
    push(0, 4'h3, 0, 0, 4); push(0, 4'hC, 0, 0, 3); push(0, 4'h8, 1, 0, 0);
    pulse(0, ARR);
    wait_leds(0, 4'hC);
    drv[0][ARR] = 1'b1;
    drv[0][DEP] = 1'b1;
    step(1);
    drv[0][ARR] = 1'b0;
    drv[0][DEP] = 1'b0;
    wait_leds(0, 4'h8);
    push(0, 4'hD, 1, 0, 0);
    door(0, OSW, 1);
    step(1);
    push(0, 4'h4, 0, 0, 0);
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if (obs[0] != {4'h4, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_drain dut0: %h, required 400", obs[0]);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    step(1);
    push(0, 4'h3, 0, 0, 4); push(0, 4'hC, 0, 0, 3); push(0, 4'h8, 1, 0, 0);
    pulse(0, ARR);
    wait_leds(0, 4'h8);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      step(1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: %0d entries left, required 0", q.size());
    end
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
